// File: rtl/wb_grf_pkg.sv
// wb_pkg: shared constants and types for the write-back register file slice.
//   DEF_DATA_W   default register/data width
//   REG_ZERO     hard-wired zero register index
//   REG_RA       return-address register index (target of link writes)
//   trace_rec_t  trace record {pc, addr, data} at the default data width
//   TRACE_REC_W  width of trace_rec_t
package wb_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [31:0]           pc;
    logic [4:0]            addr;
    logic [DEF_DATA_W-1:0] data;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: single-clock FIFO for commit trace records.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   push, push_rec     enqueue request and record
//   pop_ready          consumer accepts the head record (ignored when empty)
//   head_valid         FIFO non-empty
//   head_rec           head record, all zeros when empty
//   count              records queued, 0..2**DEPTH_LOG2
//   ovf                sticky: a push was dropped because the FIFO was full
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
// Pushed records appear on head_rec one cycle after the push edge.
module wb_trace_fifo #(
  parameter int REC_W      = 69,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REC_W-1:0]      push_rec,
  input  logic                  pop_ready,
  output logic                  head_valid,
  output logic [REC_W-1:0]      head_rec,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [REC_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  ovf_q;

  logic empty;
  logic full;
  logic pop_ok;
  logic push_ok;
  logic drop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_CNT);
  assign pop_ok  = pop_ready && !empty;
  // A full FIFO frees its head slot in the same edge when popped.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage is data only; visibility is governed entirely by cnt/rd_ptr.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_rec;
  end

  assign head_valid = !empty;
  assign head_rec   = empty ? '0 : mem[rd_ptr];
  assign count      = cnt;
  assign ovf        = ovf_q;

endmodule

// File: rtl/wb_grf.sv
// wb_grf: W-stage write-back into a 32 x DATA_W general register file with
// two combinational read ports and a commit trace FIFO.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   w_we, w_addr, w_data, w_pc     retiring instruction write request
//   r_addr1/r_data1, r_addr2/r_data2  D-stage read ports (reg 0 reads 0)
//   trace_valid/trace_ready        trace head handshake
//   trace_pc/addr/data             head record (0 when empty)
//   trace_count                    records queued
//   trace_ovf                      sticky record-dropped flag
// Build option WB_GRF_BYPASS_EN: read ports return the W-stage value in the
// same cycle it is committed (write-first). Without it, reads see the
// pre-edge array and an external W->D forward is required.
module wb_grf
  import wb_pkg::*;
#(
  parameter int DATA_W           = DEF_DATA_W,
  parameter int TRACE_DEPTH_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_we,
  input  logic [4:0]              w_addr,
  input  logic [DATA_W-1:0]       w_data,
  input  logic [31:0]             w_pc,
  input  logic [4:0]              r_addr1,
  input  logic [4:0]              r_addr2,
  output logic [DATA_W-1:0]       r_data1,
  output logic [DATA_W-1:0]       r_data2,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [31:0]             trace_pc,
  output logic [4:0]              trace_addr,
  output logic [DATA_W-1:0]       trace_data,
  output logic [TRACE_DEPTH_LOG2:0] trace_count,
  output logic                    trace_ovf
);

  localparam int REC_W = 32 + 5 + DATA_W;

  logic [DATA_W-1:0] regs [32];
  logic              commit;
  logic [REC_W-1:0]  head_rec;

  // Writes to register 0 are dropped entirely, including their trace record.
  assign commit = w_we && (w_addr != REG_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[w_addr] <= w_data;
    end
  end

  always_comb begin
    r_data1 = (r_addr1 == REG_ZERO) ? '0 : regs[r_addr1];
    r_data2 = (r_addr2 == REG_ZERO) ? '0 : regs[r_addr2];
`ifdef WB_GRF_BYPASS_EN
    // commit already excludes register 0, so the zero read is preserved.
    if (commit && (r_addr1 == w_addr)) r_data1 = w_data;
    if (commit && (r_addr2 == w_addr)) r_data2 = w_data;
`endif
  end

  wb_trace_fifo #(
    .REC_W      (REC_W),
    .DEPTH_LOG2 (TRACE_DEPTH_LOG2)
  ) u_trace_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (commit),
    .push_rec   ({w_pc, w_addr, w_data}),
    .pop_ready  (trace_ready),
    .head_valid (trace_valid),
    .head_rec   (head_rec),
    .count      (trace_count),
    .ovf        (trace_ovf)
  );

  assign {trace_pc, trace_addr, trace_data} = head_rec;

endmodule

// File: tb/tb_wb_grf.sv
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] w_pc;
  logic [4:0]  r_addr1;
  logic [4:0]  r_addr2;
  logic [31:0] r_data1;
  logic [31:0] r_data2;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [3:0]  trace_count;
  logic        trace_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  wb_grf #(.DATA_W(32), .TRACE_DEPTH_LOG2(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .w_pc        (w_pc),
    .r_addr1     (r_addr1),
    .r_addr2     (r_addr2),
    .r_data1     (r_data1),
    .r_data2     (r_data2),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .trace_count (trace_count),
    .trace_ovf   (trace_ovf)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    w_we = 1'b0; w_addr = '0; w_data = '0; w_pc = '0;
    r_addr1 = '0; r_addr2 = '0; trace_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 32; i++) begin
      r_addr1 = 5'(i);
      r_addr2 = 5'(31 - i);
      #1;
      n_cmp++;
      if (r_data1 !== 32'h0) begin
        n_bad++; $display("FAIL reset_rd1 reg%0d got %h want 0", i, r_data1);
      end
      n_cmp++;
      if (r_data2 !== 32'h0) begin
        n_bad++; $display("FAIL reset_rd2 reg%0d got %h want 0", 31 - i, r_data2);
      end
    end
    n_cmp++;
    if (trace_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", trace_valid); end
    n_cmp++;
    if (trace_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", trace_count); end
    n_cmp++;
    if (trace_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", trace_ovf); end
    n_cmp++;
    if ({trace_pc, trace_addr, trace_data} !== 69'h0) begin
      n_bad++; $display("FAIL reset_head got %h/%0d/%h want 0", trace_pc, trace_addr, trace_data);
    end
  endtask

  task automatic test_write();
    w_we = 1'b1; w_addr = 5'd5; w_data = 32'h12345678; w_pc = 32'h3000;
    r_addr1 = 5'd5;
    step();
    w_we = 1'b0;
    #1;
    n_cmp++;
    if (r_data1 !== 32'h12345678) begin n_bad++; $display("FAIL wr_read got %h want 12345678", r_data1); end
    n_cmp++;
    if (trace_valid !== 1'b1) begin n_bad++; $display("FAIL wr_valid got %b want 1", trace_valid); end
    n_cmp++;
    if (trace_pc !== 32'h3000 || trace_addr !== 5'd5 || trace_data !== 32'h12345678) begin
      n_bad++; $display("FAIL wr_record got %h/%0d/%h want 3000/5/12345678", trace_pc, trace_addr, trace_data);
    end
    n_cmp++;
    if (trace_count !== 4'd1) begin n_bad++; $display("FAIL wr_count got %0d want 1", trace_count); end
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    n_cmp++;
    if (trace_count !== 4'd0) begin n_bad++; $display("FAIL pop_count got %0d want 0", trace_count); end
    n_cmp++;
    if (trace_valid !== 1'b0 || trace_pc !== 32'h0 || trace_data !== 32'h0) begin
      n_bad++; $display("FAIL pop_head got v=%b %h/%h want 0", trace_valid, trace_pc, trace_data);
    end
  endtask

  task automatic test_zero_write();
    w_we = 1'b1; w_addr = 5'd0; w_data = 32'hFFFFFFFF; w_pc = 32'h3004;
    r_addr1 = 5'd0; r_addr2 = 5'd0;
    #1;
    n_cmp++;
    if (r_data1 !== 32'h0) begin n_bad++; $display("FAIL zero_same_cycle got %h want 0", r_data1); end
    step();
    w_we = 1'b0;
    n_cmp++;
    if (r_data1 !== 32'h0 || r_data2 !== 32'h0) begin
      n_bad++; $display("FAIL zero_read got %h/%h want 0/0", r_data1, r_data2);
    end
    n_cmp++;
    if (trace_count !== 4'd0 || trace_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_trace got count=%0d v=%b want 0/0", trace_count, trace_valid);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
    w_we = 1'b1; w_addr = 5'd31; w_data = 32'hAAAA5555; w_pc = 32'h3008;
    step();
    w_we = 1'b1; w_addr = 5'd31; w_data = 32'h00003008; w_pc = 32'h300C;
    r_addr2 = 5'd31;
    #1;
`ifdef WB_GRF_BYPASS_EN
    exp_now = 32'h00003008;
`else
    exp_now = 32'hAAAA5555;
`endif
    n_cmp++;
    if (r_data2 !== exp_now) begin n_bad++; $display("FAIL same_cycle_rd2 got %h want %h", r_data2, exp_now); end
    step();
    w_we = 1'b0;
    n_cmp++;
    if (r_data2 !== 32'h00003008) begin n_bad++; $display("FAIL next_cycle_rd2 got %h want 00003008", r_data2); end
    n_cmp++;
    if (trace_count !== 4'd2 || trace_data !== 32'hAAAA5555 || trace_pc !== 32'h3008) begin
      n_bad++; $display("FAIL ra_trace got count=%0d %h/%h want 2/3008/aaaa5555", trace_count, trace_pc, trace_data);
    end
    trace_ready = 1'b1;
    step();
    n_cmp++;
    if (trace_data !== 32'h00003008 || trace_addr !== 5'd31) begin
      n_bad++; $display("FAIL ra_second got %0d/%h want 31/00003008", trace_addr, trace_data);
    end
    step();
    trace_ready = 1'b0;
    n_cmp++;
    if (trace_count !== 4'd0) begin n_bad++; $display("FAIL ra_drain got %0d want 0", trace_count); end
  endtask

  task automatic test_overflow();
    trace_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      w_we = 1'b1; w_addr = 5'(i); w_data = 32'h100 + 32'(i); w_pc = 32'h4000 + 32'(4 * i);
      step();
    end
    w_we = 1'b0;
    n_cmp++;
    if (trace_count !== 4'd8) begin n_bad++; $display("FAIL ovf_count got %0d want 8", trace_count); end
    n_cmp++;
    if (trace_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", trace_ovf); end
    r_addr1 = 5'd9;
    #1;
    n_cmp++;
    if (r_data1 !== 32'h109) begin n_bad++; $display("FAIL ovf_reg9 got %h want 109", r_data1); end
    trace_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (trace_valid !== 1'b1 || trace_addr !== 5'(i) || trace_data !== 32'h100 + 32'(i) ||
          trace_pc !== 32'h4000 + 32'(4 * i)) begin
        n_bad++; $display("FAIL drain_%0d got v=%b %h/%0d/%h want %h/%0d/%h", i, trace_valid,
                          trace_pc, trace_addr, trace_data, 32'h4000 + 32'(4 * i), i, 32'h100 + 32'(i));
      end
      step();
    end
    trace_ready = 1'b0;
    n_cmp++;
    if (trace_count !== 4'd0 || trace_valid !== 1'b0) begin
      n_bad++; $display("FAIL drain_empty got count=%0d v=%b want 0/0", trace_count, trace_valid);
    end
    n_cmp++;
    if (trace_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", trace_ovf); end
  endtask

  task automatic test_full_push_pop();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_we = 1'b1; w_addr = 5'(10 + i); w_data = 32'h200 + 32'(i); w_pc = 32'h5000 + 32'(4 * i);
      step();
    end
    w_we = 1'b0;
    n_cmp++;
    if (trace_count !== 4'd8 || trace_ovf !== 1'b0) begin
      n_bad++; $display("FAIL fill got count=%0d ovf=%b want 8/0", trace_count, trace_ovf);
    end
    // Push and pop together on a full FIFO.
    w_we = 1'b1; w_addr = 5'd20; w_data = 32'h300; w_pc = 32'h6000;
    trace_ready = 1'b1;
    step();
    w_we = 1'b0; trace_ready = 1'b0;
    n_cmp++;
    if (trace_count !== 4'd8 || trace_ovf !== 1'b0) begin
      n_bad++; $display("FAIL full_pushpop got count=%0d ovf=%b want 8/0", trace_count, trace_ovf);
    end
    n_cmp++;
    if (trace_addr !== 5'd11 || trace_data !== 32'h201) begin
      n_bad++; $display("FAIL full_pushpop_head got %0d/%h want 11/201", trace_addr, trace_data);
    end
    // Push alone on a full FIFO now drops.
    w_we = 1'b1; w_addr = 5'd21; w_data = 32'h301; w_pc = 32'h6004;
    step();
    w_we = 1'b0;
    n_cmp++;
    if (trace_count !== 4'd8 || trace_ovf !== 1'b1) begin
      n_bad++; $display("FAIL full_drop got count=%0d ovf=%b want 8/1", trace_count, trace_ovf);
    end
    trace_ready = 1'b1;
    step();
    n_cmp++;
    if (trace_count !== 4'd7 || trace_addr !== 5'd12) begin
      n_bad++; $display("FAIL mid_drain got count=%0d addr=%0d want 7/12", trace_count, trace_addr);
    end
    // Asynchronous reset mid-drain, with a write pending in the same cycle.
    w_we = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF; w_pc = 32'h7000;
    r_addr1 = 5'd11; r_addr2 = 5'd20;
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (trace_count !== 4'd0 || trace_ovf !== 1'b0 || trace_valid !== 1'b0) begin
      n_bad++; $display("FAIL async_rst_fifo got count=%0d ovf=%b v=%b want 0/0/0", trace_count, trace_ovf, trace_valid);
    end
    n_cmp++;
    if (r_data1 !== 32'h0 || r_data2 !== 32'h0) begin
      n_bad++; $display("FAIL async_rst_regs got %h/%h want 0/0", r_data1, r_data2);
    end
    step();
    reset = 1'b0;
    w_we = 1'b0; trace_ready = 1'b0;
    r_addr1 = 5'd5;
    #1;
    n_cmp++;
    if (r_data1 !== 32'h0 || trace_count !== 4'd0) begin
      n_bad++; $display("FAIL rst_write_discard got reg5=%h count=%0d want 0/0", r_data1, trace_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_zero_write();
    test_same_cycle();
    test_overflow();
    test_full_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back end of the W-stage register-write interface.
- Consumes the decoded destination address, write data, write enable and PC of the retiring instruction, and commits them to a 32x32 general register file.
- Serves two combinational read ports to the D stage.
- Queues every committed write as a trace record in a small FIFO, drained by a valid/ready consumer (bench/trace printer).

Parameters:
- DATA_W, 32, register and data width.
- TRACE_DEPTH_LOG2, 3, log2 of trace FIFO depth (default 8 entries).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- w_we  in  1  W-stage write request.
- w_addr  in  5  destination register from W-stage decode (0 = no write).
- w_data  in  DATA_W  value selected by W-stage (ALU result / DM data / PC+8).
- w_pc  in  32  PC of the retiring instruction.
- r_addr1  in  5  read port 1 address (rs).
- r_addr2  in  5  read port 2 address (rt).
- r_data1  out  DATA_W  read port 1 data.
- r_data2  out  DATA_W  read port 2 data.
- trace_valid  out  1  trace FIFO non-empty.
- trace_ready  in  1  consumer accepts head record.
- trace_pc  out  32  head record PC.
- trace_addr  out  5  head record register.
- trace_data  out  DATA_W  head record value.
- trace_count  out  TRACE_DEPTH_LOG2+1  records currently queued.
- trace_ovf  out  1  sticky: a record was dropped.

Behaviour:
- Reset (async assert, released synchronously to clk by the environment):
  - all 32 registers = 0; FIFO empty.
  - trace_valid = 0, trace_count = 0, trace_ovf = 0.
  - trace_pc/addr/data = 0.
  - Reset mid-traffic discards queued records and any write in that cycle.
- Effective write: commit = w_we && (w_addr != 0). Register w_addr takes w_data at the edge.
  - w_we with w_addr == 0 is ignored entirely: no register change, no trace record.
- Register 0 always reads 0 on both ports.
- Reads are combinational from the array; both ports may read the same address.
- Trace push:
  - Each commit pushes {w_pc, w_addr, w_data}.
  - Record becomes visible on the trace_* outputs the cycle after the push edge. No fall-through.
- Trace pop: trace_valid && trace_ready at an edge removes the head. trace_* outputs hold steady while valid && !ready.
- FIFO boundaries:
  - Empty: trace_ready is ignored.
  - Full with push and no pop: record dropped, trace_ovf set (cleared only by reset), count stays at depth.
  - Full with push and pop in the same cycle: both succeed, count unchanged, no overflow.
  - Empty with push and pop in the same cycle: push only (nothing to pop).
- Read/write/FIFO pointers wrap modulo depth. trace_count ranges 0..2^TRACE_DEPTH_LOG2.
- Head outputs are 0 when empty.

Optional Feature:
- WB_GRF_BYPASS_EN defined:
  - Internal write-first bypass: if commit && r_addrN == w_addr, r_dataN = w_data in the same cycle.
  - Removes the need for a W->D forward path.
- Not defined:
  - r_dataN returns the pre-edge array value.
  - The external hazard unit must forward W->D.

Decomposition:
- Package wb_pkg:
  - REG_ZERO = 5'd0, REG_RA = 5'd31.
  - DATA_W default.
  - Trace record type {pc[31:0], addr[4:0], data[31:0]} and its width constant.
- Sub-module: wb_trace_fifo — synchronous single-clock FIFO with valid/ready pop, count, and sticky overflow.
  - Parameterised by record width and TRACE_DEPTH_LOG2.
  - wb_grf holds the array, the read/bypass logic and the commit logic.

Test Plan:
- Reset, then read all 32 regs: r_data1/2 = 0, trace_valid = 0, trace_ovf = 0.
- Write w_addr=5, w_data=0x12345678, w_pc=0x3000. Next cycle:
  - r_addr1=5 gives 0x12345678.
  - trace_valid = 1 with {0x3000, 5, 0x12345678}.
  - Pop with ready=1 gives count 0.
- Write w_addr=0, w_data=0xFFFFFFFF, we=1: r_data of reg 0 = 0, no trace record (count stays 0).
- Same-cycle write reg 31 = 0x00003008 while r_addr2=31:
  - bypass build: r_data2 = 0x00003008 that cycle.
  - non-bypass build: old value that cycle, new value next cycle.
- Hold trace_ready=0 and commit 9 writes (regs 1..9) with depth 8:
  - count = 8, trace_ovf = 1.
  - Draining yields regs 1..8 in order; reg 9 absent.
- FIFO full: push + pop same cycle gives count stays 8, no new overflow. Then assert reset mid-drain: count = 0, trace_ovf = 0, regs = 0 immediately.
